fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch. Each cycle it picks the next PC from the reset vector, a trap vector, a branch/jump redirect or PC+4. It issues one request at a time to instruction memory over a valid/ready handshake and presents the returned instruction, tagged with its PC, to decode. Sits between the instruction memory port and the decode stage.

## Interface
- DATA_WIDTH_P, 32, PC, address and instruction width
- RESET_VECTOR_P, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR_P, 32'h0000_0100, fetch address taken on trap
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_trap_valid  in  1  trap request, single-cycle pulse
- i_redirect_valid  in  1  branch/jump taken, single-cycle pulse
- i_redirect_pc  in  DATA_WIDTH_P  redirect target
- o_imem_req_valid  out  1  fetch request valid
- i_imem_req_ready  in  1  imem accepts request
- o_imem_addr  out  DATA_WIDTH_P  fetch address (current PC)
- i_imem_rsp_valid  in  1  instruction data returned
- i_imem_rsp_data  in  DATA_WIDTH_P  instruction word
- o_inst_valid  out  1  instruction available to decode
- i_inst_ready  in  1  decode accepts instruction
- o_inst  out  DATA_WIDTH_P  instruction word
- o_inst_pc  out  DATA_WIDTH_P  PC of o_inst
- o_misaligned  out  1  redirect target misaligned (only with FETCH_SEQ_MISALIGN_TRAP_EN)

## Operation
- States: REQ (request driven), WAIT (request accepted, response pending), HOLD (instruction presented to decode).
- Reset: state REQ, pc = RESET_VECTOR_P, kill = 0, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0, o_misaligned = 0.
- o_imem_req_valid = (state == REQ). o_imem_addr = pc.
- REQ: on valid && ready, go to WAIT and latch req_pc = pc.
- WAIT: on i_imem_rsp_valid with kill = 0, register o_inst = rsp_data, o_inst_pc = req_pc, set o_inst_valid, go to HOLD.
- WAIT: on response with kill = 1, discard it, clear kill, go to REQ.
- HOLD: on i_inst_ready, clear o_inst_valid, set pc = pc + 4, go to REQ.
- Next-PC priority: trap > redirect > sequential (+4) > hold.
- Redirect or trap in REQ with no handshake: pc updates; the request stays valid with the new address. The imem samples the address only on handshake.
- Redirect or trap in REQ on the handshake cycle: pc updates, go to WAIT with kill = 1.
- Redirect or trap in WAIT: pc updates, kill = 1. If the response arrives the same cycle, discard it and go to REQ.
- Redirect or trap in HOLD: drop o_inst_valid, pc updates, go to REQ. If i_inst_ready is high the same cycle, the instruction counts as consumed, but pc takes the target, not +4.
- Arithmetic: pc + 4 wraps modulo 2^DATA_WIDTH_P.
- Reset mid-operation: return to the reset state; a response arriving after reset while in REQ is ignored.
- Outstanding requests: at most one.

## Timing
- First request is on the first cycle after reset deasserts.
- Response at cycle t gives o_inst_valid at t+1.
- Zero-wait imem: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect latency: the target appears on o_imem_addr the cycle after the pulse.
- o_inst and o_inst_pc stay stable while o_inst_valid && !i_inst_ready.

## Configuration
- FETCH_SEQ_MISALIGN_TRAP_EN defined:
  - A redirect with i_redirect_pc[1:0] != 0 sets o_misaligned for one cycle.
  - pc is loaded with TRAP_VECTOR_P instead of the target.
- Undefined:
  - o_misaligned is absent.
  - The redirect target loads with bits [1:0] forced to 0.

## Structure
- Shared package fetch_pkg:
  - state enum {REQ, WAIT, HOLD}
  - INST_BYTES = 4
  - next-PC select enum {SEL_TRAP, SEL_REDIR, SEL_SEQ, SEL_HOLD}
- Sub-module fetch_pc_select: combinational priority mux producing next pc and select code. All registers stay in fetch_sequencer.

## Test plan
- Reset, i_imem_req_ready = 1, 1-cycle response latency, i_inst_ready = 1 -> addresses 0x0, 0x4, 0x8 and o_inst_pc matches each.
- Redirect to 0x200 while in WAIT -> stale response discarded, next o_imem_addr = 0x200, next o_inst_pc = 0x200.
- Trap and redirect (0x300) in the same cycle -> next address = 0x100.
- HOLD with i_inst_ready = 0 for 5 cycles -> o_inst and o_inst_pc stable, no new request; ready then gives next address pc + 4.
- pc = 0xFFFF_FFFC consumed -> next address 0x0000_0000.
- Redirect to 0x202:
  - macro defined -> o_misaligned pulses, address 0x100.
  - macro undefined -> address 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  // Next-PC source, highest priority first.
  typedef enum logic [1:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_pc_select.sv
// Combinational next-PC priority mux: trap > redirect > sequential > hold.
// Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN (misaligned redirect
// targets are replaced by the trap vector and flagged).
import fetch_pkg::*;

module fetch_pc_select #(
  parameter int unsigned                 DATA_WIDTH_P  = 32,
  parameter logic [DATA_WIDTH_P-1:0]     TRAP_VECTOR_P = 32'h0000_0100
) (
  input  logic                    i_trap_valid,
  input  logic                    i_redirect_valid,
  input  logic [DATA_WIDTH_P-1:0] i_redirect_pc,
  input  logic                    i_advance,
  input  logic [DATA_WIDTH_P-1:0] i_pc,
  output logic [DATA_WIDTH_P-1:0] o_next_pc,
  output pc_sel_e                 o_sel
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  ,
  output logic                    o_misaligned
`endif
);

  localparam logic [DATA_WIDTH_P-1:0] LOW_MASK = DATA_WIDTH_P'(INST_BYTES - 1);

  logic                    w_low_bits_set;
  logic [DATA_WIDTH_P-1:0] w_redir_target;

  assign w_low_bits_set = (i_redirect_pc & LOW_MASK) != '0;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign w_redir_target = w_low_bits_set ? TRAP_VECTOR_P : i_redirect_pc;
  assign o_misaligned   = i_redirect_valid && !i_trap_valid && w_low_bits_set;
`else
  // Misaligned targets are silently word-aligned.
  assign w_redir_target = i_redirect_pc & ~LOW_MASK;
`endif

  // Priority selection of the next program counter.
  always_comb begin
    o_sel     = SEL_HOLD;
    o_next_pc = i_pc;
    if (i_trap_valid) begin
      o_sel     = SEL_TRAP;
      o_next_pc = TRAP_VECTOR_P;
    end else if (i_redirect_valid) begin
      o_sel     = SEL_REDIR;
      o_next_pc = w_redir_target;
    end else if (i_advance) begin
      o_sel     = SEL_SEQ;
      o_next_pc = i_pc + DATA_WIDTH_P'(INST_BYTES);
    end
  end

`ifndef FETCH_SEQ_MISALIGN_TRAP_EN
  logic w_unused;
  assign w_unused = w_low_bits_set;
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem request at a time and
// presents the returned instruction (tagged with its PC) to decode.
// Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN (adds o_misaligned).
import fetch_pkg::*;

module fetch_sequencer #(
  parameter int unsigned             DATA_WIDTH_P   = 32,
  parameter logic [DATA_WIDTH_P-1:0] RESET_VECTOR_P = 32'h0000_0000,
  parameter logic [DATA_WIDTH_P-1:0] TRAP_VECTOR_P  = 32'h0000_0100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_trap_valid,
  input  logic                    i_redirect_valid,
  input  logic [DATA_WIDTH_P-1:0] i_redirect_pc,
  output logic                    o_imem_req_valid,
  input  logic                    i_imem_req_ready,
  output logic [DATA_WIDTH_P-1:0] o_imem_addr,
  input  logic                    i_imem_rsp_valid,
  input  logic [DATA_WIDTH_P-1:0] i_imem_rsp_data,
  output logic                    o_inst_valid,
  input  logic                    i_inst_ready,
  output logic [DATA_WIDTH_P-1:0] o_inst,
  output logic [DATA_WIDTH_P-1:0] o_inst_pc
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  ,
  output logic                    o_misaligned
`endif
);

  fetch_state_e            r_state, w_state_nxt;
  logic [DATA_WIDTH_P-1:0] r_pc;
  logic [DATA_WIDTH_P-1:0] r_req_pc, w_req_pc_nxt;
  logic                    r_kill, w_kill_nxt;
  logic                    r_inst_valid, w_inst_valid_nxt;
  logic [DATA_WIDTH_P-1:0] r_inst, w_inst_nxt;
  logic [DATA_WIDTH_P-1:0] r_inst_pc, w_inst_pc_nxt;

  logic [DATA_WIDTH_P-1:0] w_next_pc;
  pc_sel_e                 w_sel;
  logic                    w_advance;
  logic                    w_redir_any;

  assign w_advance   = (r_state == HOLD) && i_inst_ready;
  assign w_redir_any = (w_sel == SEL_TRAP) || (w_sel == SEL_REDIR);

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  logic w_misaligned;
  logic r_misaligned;
`endif

  fetch_pc_select #(
    .DATA_WIDTH_P  (DATA_WIDTH_P),
    .TRAP_VECTOR_P (TRAP_VECTOR_P)
  ) u_pc_select (
    .i_trap_valid     (i_trap_valid),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_advance        (w_advance),
    .i_pc             (r_pc),
    .o_next_pc        (w_next_pc),
    .o_sel            (w_sel)
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    ,
    .o_misaligned     (w_misaligned)
`endif
  );

  assign o_imem_req_valid = (r_state == REQ);
  assign o_imem_addr      = r_pc;
  assign o_inst_valid     = r_inst_valid;
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_inst_pc;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign o_misaligned     = r_misaligned;
`endif

  // Next-state and datapath decisions for the request/response/hold cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_pc_nxt     = r_req_pc;
    w_kill_nxt       = r_kill;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    unique case (r_state)
      REQ: begin
        if (i_imem_req_ready) begin
          w_state_nxt  = WAIT;
          w_req_pc_nxt = r_pc;
          // A redirect on the handshake cycle makes the in-flight fetch stale.
          w_kill_nxt   = w_redir_any;
        end
      end
      WAIT: begin
        if (i_imem_rsp_valid) begin
          w_kill_nxt = 1'b0;
          if (r_kill || w_redir_any) begin
            w_state_nxt = REQ;
          end else begin
            w_inst_nxt       = i_imem_rsp_data;
            w_inst_pc_nxt    = r_req_pc;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = HOLD;
          end
        end else if (w_redir_any) begin
          w_kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (w_redir_any || i_inst_ready) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = REQ;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= REQ;
      r_pc         <= RESET_VECTOR_P;
      r_req_pc     <= '0;
      r_kill       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_next_pc;
      r_req_pc     <= w_req_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  // One-cycle misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (reset) r_misaligned <= 1'b0;
    else       r_misaligned <= w_misaligned;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
// Honours FETCH_SEQ_MISALIGN_TRAP_EN when defined for the build.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_trap_valid, i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid, i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_inst_pc;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  fetch_sequencer #(
    .DATA_WIDTH_P   (32),
    .RESET_VECTOR_P (RST_VEC),
    .TRAP_VECTOR_P  (TRAP_VEC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_trap_valid     (i_trap_valid),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc)
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    ,
    .o_misaligned     (o_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: architectural PC, the one outstanding fetch,
  // and the instruction currently offered to decode.
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] m_out_addr;
  bit          m_killed;
  int unsigned m_lat_left;
  bit          m_valid;
  logic [31:0] m_inst, m_inst_pc;
  bit          m_mis;

  bit          g_lat_rand = 1'b0;
  int unsigned g_lat      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  task automatic model_reset();
    m_pc = RST_VEC; m_out = 1'b0; m_out_addr = '0; m_killed = 1'b0;
    m_lat_left = 0; m_valid = 1'b0; m_inst = '0; m_inst_pc = '0; m_mis = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_trap_valid = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
    i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
    i_inst_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_inst_valid", {31'b0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("rst_addr", o_imem_addr, RST_VEC);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    chk("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit trap, input bit redir, input logic [31:0] rpc,
                      input bit rq_rdy, input bit in_rdy, input bit stray);
    bit          hs, cons, rsp_taken, redir_any, pre_valid;
    logic [31:0] pre_inst, pre_pc, tgt, old_pc;
    bit          mis;
    i_trap_valid = trap; i_redirect_valid = redir; i_redirect_pc = rpc;
    i_imem_req_ready = rq_rdy; i_inst_ready = in_rdy;
    i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'hDEAD_BEEF;
    if (m_out) begin
      if (m_lat_left == 0) begin
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = mem_word(m_out_addr);
      end else begin
        m_lat_left--;
      end
    end else if (stray) begin
      i_imem_rsp_valid = 1'b1;
    end
    hs        = o_imem_req_valid && rq_rdy;
    cons      = o_inst_valid && in_rdy;
    rsp_taken = i_imem_rsp_valid && m_out;
    pre_valid = o_inst_valid; pre_inst = o_inst; pre_pc = o_inst_pc;
    @(posedge clk); #1;
    i_trap_valid = 1'b0; i_redirect_valid = 1'b0; i_imem_rsp_valid = 1'b0;

    redir_any = trap || redir;
    mis = redir && !trap && (rpc[1:0] != 2'b00);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    tgt = mis ? TRAP_VEC : rpc;
    m_mis = mis;
`else
    tgt = {rpc[31:2], 2'b00};
`endif
    old_pc = m_pc;
    if (trap)       m_pc = TRAP_VEC;
    else if (redir) m_pc = tgt;
    else if (cons)  m_pc = old_pc + 32'd4;
    if (m_valid && (cons || redir_any)) m_valid = 1'b0;
    if (rsp_taken) begin
      m_out = 1'b0;
      if (!(m_killed || redir_any)) begin
        m_valid = 1'b1; m_inst_pc = m_out_addr; m_inst = mem_word(m_out_addr);
      end
    end else if (m_out && redir_any) begin
      m_killed = 1'b1;
    end
    if (hs) begin
      m_out = 1'b1; m_out_addr = old_pc; m_killed = redir_any;
      m_lat_left = g_lat_rand ? $urandom_range(0, 3) : g_lat;
    end

    if (pre_valid && !in_rdy && !redir_any) begin
      chk("stable_inst", o_inst, pre_inst);
      chk("stable_pc", o_inst_pc, pre_pc);
    end
    chk("addr", o_imem_addr, m_pc);
    chk("req_valid", {31'b0, o_imem_req_valid}, {31'b0, (!m_out && !m_valid)});
    chk("inst_valid", {31'b0, o_inst_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("inst", o_inst, m_inst);
      chk("inst_pc", o_inst_pc, m_inst_pc);
    end
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    chk("misaligned", {31'b0, o_misaligned}, {31'b0, m_mis});
`endif
  endtask

  // Accept requests and wait (bounded) for an instruction without consuming it.
  task automatic wait_inst();
    for (int k = 0; k < 12; k++) begin
      if (o_inst_valid) break;
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("wait_inst", {31'b0, o_inst_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] h_inst, h_pc, rpc;
    int unsigned n_req, n_del;
    bit          tr, rd;
    model_reset();
    do_reset();

    // Back-to-back sequential fetch with single-cycle imem.
    g_lat_rand = 1'b0; g_lat = 0;
    n_req = 0; n_del = 0;
    repeat (9) begin
      if (o_imem_req_valid) begin
        chk("seq_addr", o_imem_addr, n_req * 4);
        n_req++;
      end
      if (o_inst_valid) begin
        chk("seq_inst_pc", o_inst_pc, n_del * 4);
        n_del++;
      end
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    chk("seq_count", n_del, 32'd3);

    // Redirect while waiting: stale response must be dropped.
    do_reset();
    g_lat = 1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    chk("redir_addr", o_imem_addr, 32'h200);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("redir_drop", {31'b0, o_inst_valid}, 32'd0);
    g_lat = 0;
    wait_inst();
    chk("redir_inst_pc", o_inst_pc, 32'h200);

    // Trap beats redirect in the same cycle.
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    chk("trap_prio_addr", o_imem_addr, TRAP_VEC);

    // Decode stall: instruction held, no new request.
    wait_inst();
    h_inst = o_inst; h_pc = o_inst_pc;
    repeat (5) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("stall_inst", o_inst, h_inst);
      chk("stall_req", {31'b0, o_imem_req_valid}, 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stall_next_addr", o_imem_addr, h_pc + 32'd4);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    wait_inst();
    chk("wrap_inst_pc", o_inst_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("wrap_addr", o_imem_addr, 32'h0);

    // Misaligned redirect target.
    step(1'b0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, o_misaligned}, 32'd1);
    chk("mis_addr", o_imem_addr, TRAP_VEC);
`else
    chk("mis_addr", o_imem_addr, 32'h200);
`endif

    // Reset with a fetch in flight; a late response must be ignored.
    g_lat = 2;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("post_rst_ignore", {31'b0, o_inst_valid}, 32'd0);

    // Randomized traffic.
    g_lat_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 255) == 0) begin
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      end
      tr = ($urandom_range(0, 31) == 0);
      rd = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       rpc = $urandom & 32'h0000_0FFC;
        default: rpc = ($urandom & 32'h0000_0FFF) | 32'h1;
      endcase
      step(tr, rd, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
